led_demo_scheduler: RTL and testbench

- Front-panel sequencer for the pocket LED board: owns the shared LED display and the launch lines of up to eight demo modules.
- Debounces the push-keys and lets the user select a module with next/prev.
- Launches the selected module with an active-low one-hot command and supervises its active-low feedback handshake.
- Detects modules that never acknowledge, and detects conflicts (more than one module running).

---
 rtl/led_demo_pkg.sv | 24 ++
 rtl/key_debounce.sv | 45 ++++
 rtl/led_demo_scheduler.sv | 157 +++++++++++++++
 tb/tb_led_demo_scheduler.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_demo_pkg.sv
// rtl/led_demo_pkg.sv - shared types and constants for the LED demo scheduler
package led_demo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        RELEASE,
        FAULT
    } state_t;

    localparam int KEY_START = 0;
    localparam int KEY_NEXT  = 1;
    localparam int KEY_PREV  = 2;
    localparam int KEY_STOP  = 3;

    localparam logic [7:0] CMD_NONE  = 8'hFF;
    localparam logic [7:0] LED_FAULT = 8'hFF;

    function automatic logic [7:0] onehot(input logic [2:0] s);
        return 8'h01 << s;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one push-key: synchroniser, debounce counter, press pulse
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] cnt;

    // The level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples;
    // the press pulse is taken from the registered falling edge of that level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync1   <= key;
            sync2   <= sync1;
            level_d <= level;
            press   <= level_d & ~level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_demo_scheduler.sv
// rtl/led_demo_scheduler.sv - front-panel launcher/supervisor for eight demo modules (option: AUTO_CYCLE_EN)
module led_demo_scheduler
    import led_demo_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ACK_TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] keys,
    input  logic [7:0] feedback,
    output logic [7:0] led,
    output logic [7:0] command,
    output logic       busy,
    output logic       fault
);

    localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

    state_t      state, state_n;
    logic [2:0]  sel, sel_n;
    logic [15:0] tmo, tmo_n;
    logic [7:0]  led_n, command_n;
    logic        busy_n, fault_n;
    logic        press_start, press_next, press_prev, press_stop;
    logic        ev_start, ev_next, ev_prev, ev_stop;
    logic [7:0]  sel_mask;
    logic        fb_clear, own_busy, foreign;
    logic        unused_keys;

    assign unused_keys = ^keys[6:4];

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk(clk), .rst(rst), .key(keys[KEY_START]), .press(press_start));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk(clk), .rst(rst), .key(keys[KEY_NEXT]), .press(press_next));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
        .clk(clk), .rst(rst), .key(keys[KEY_PREV]), .press(press_prev));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
        .clk(clk), .rst(rst), .key(keys[KEY_STOP]), .press(press_stop));

    // Only the highest-priority event of a cycle survives.
    assign ev_stop  = press_stop;
    assign ev_start = press_start & ~press_stop;
    assign ev_next  = press_next & ~press_start & ~press_stop;
    assign ev_prev  = press_prev & ~press_next & ~press_start & ~press_stop;

    assign sel_mask = onehot(sel);
    assign fb_clear = (feedback == 8'hFF);
    assign own_busy = ~feedback[sel];
    assign foreign  = |(~feedback & ~sel_mask);

`ifdef AUTO_CYCLE_EN
    logic auto_armed, auto_armed_n;

    always_ff @(posedge clk) begin
        if (rst) auto_armed <= 1'b0;
        else     auto_armed <= auto_armed_n;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sel     <= 3'd0;
            tmo     <= '0;
            led     <= 8'h01;
            command <= CMD_NONE;
            busy    <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state   <= state_n;
            sel     <= sel_n;
            tmo     <= tmo_n;
            led     <= led_n;
            command <= command_n;
            busy    <= busy_n;
            fault   <= fault_n;
        end
    end

    always_comb begin
        state_n = state;
        sel_n   = sel;
        tmo_n   = tmo;
`ifdef AUTO_CYCLE_EN
        auto_armed_n = auto_armed & ~ev_stop;
`endif
        case (state)
            IDLE: begin
                if (!ev_stop) begin
                    if (ev_start) begin
                        if (fb_clear) begin
                            state_n = LAUNCH;
                            tmo_n   = '0;
`ifdef AUTO_CYCLE_EN
                            auto_armed_n = 1'b1;
`endif
                        end
                    end
`ifdef AUTO_CYCLE_EN
                    else if (auto_armed && fb_clear) begin
                        state_n = LAUNCH;
                        tmo_n   = '0;
                    end
`endif
                    else if (ev_next) sel_n = sel + 3'd1;
                    else if (ev_prev) sel_n = sel - 3'd1;
                end
            end
            LAUNCH: begin
                tmo_n = tmo + 16'd1;
                // A late acknowledge on the final cycle still beats the timeout.
                if (foreign)              state_n = FAULT;
                else if (ev_stop)         state_n = RELEASE;
                else if (own_busy)        state_n = RUN;
                else if (tmo == TMO_LAST) state_n = FAULT;
            end
            RUN: begin
                if (foreign)                   state_n = FAULT;
                else if (ev_stop || !own_busy) state_n = RELEASE;
            end
            RELEASE: begin
                if (fb_clear) begin
                    state_n = IDLE;
`ifdef AUTO_CYCLE_EN
                    if (auto_armed && !ev_stop) sel_n = sel + 3'd1;
`endif
                end
            end
            FAULT: begin
                if (ev_stop) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        led_n     = onehot(sel_n);
        command_n = CMD_NONE;
        busy_n    = 1'b0;
        fault_n   = 1'b0;
        case (state_n)
            LAUNCH, RUN: begin
                command_n = ~onehot(sel_n);
                busy_n    = 1'b1;
            end
            RELEASE: busy_n = 1'b1;
            FAULT: begin
                led_n   = LED_FAULT;
                fault_n = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_led_demo_scheduler.sv
// tb/tb_led_demo_scheduler.sv - scoreboard bench for led_demo_scheduler with a reactive module model
module tb_led_demo_scheduler;

    localparam int D    = 16;
    localparam int TO   = 255;
    localparam int KEEP = D + 8;
    localparam logic [6:0] K_START = 7'h01;
    localparam logic [6:0] K_NEXT  = 7'h02;
    localparam logic [6:0] K_PREV  = 7'h04;
    localparam logic [6:0] K_STOP  = 7'h08;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] keys;
    logic [7:0] feedback, led, command;
    logic       busy, fault;
    logic [7:0] mod_fb = 8'hFF;
    logic [7:0] ext_fb = 8'hFF;

    assign feedback = mod_fb & ext_fb;

    always #5 clk = ~clk;

    led_demo_scheduler #(.DEBOUNCE_CYCLES(D), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .keys(keys), .feedback(feedback),
        .led(led), .command(command), .busy(busy), .fault(fault));

    typedef struct {
        logic [17:0] v;
        string       name;
    } exp_t;

    exp_t        expq[$];
    exp_t        e_m;
    int          total = 0;
    int          bad = 0;
    bit          mon_en = 0;
    logic [17:0] last;
    logic [17:0] cur;
    int          msel = 0;

    function automatic logic [7:0] bit_of(int s);
        return 8'(1 << s);
    endfunction

    // Expected display/launch outputs for each abstract phase of the scheduler.
    task automatic expect_phase(string ph, int s);
        exp_t e;
        e.name = $sformatf("%s_%0d", ph, s);
        case (ph)
            "idle":    e.v = {bit_of(s), 8'hFF, 1'b0, 1'b0};
            "launch":  e.v = {bit_of(s), ~bit_of(s), 1'b1, 1'b0};
            "release": e.v = {bit_of(s), 8'hFF, 1'b1, 1'b0};
            default:   e.v = {8'hFF, 8'hFF, 1'b0, 1'b1};
        endcase
        expq.push_back(e);
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor: every change of the output bundle must match the next expected phase.
    always @(negedge clk) begin
        if (mon_en) begin
            cur = {led, command, busy, fault};
            if (cur !== last) begin
                last = cur;
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: got led=%h cmd=%h busy=%b fault=%b want no change",
                             cur[17:10], cur[9:2], cur[1], cur[0]);
                end else begin
                    e_m = expq.pop_front();
                    if (cur !== e_m.v) begin
                        bad++;
                        $display("FAIL %s: got led=%h cmd=%h busy=%b fault=%b want led=%h cmd=%h busy=%b fault=%b",
                                 e_m.name, cur[17:10], cur[9:2], cur[1], cur[0],
                                 e_m.v[17:10], e_m.v[9:2], e_m.v[1], e_m.v[0]);
                    end
                end
            end
        end
    end

    // Demo module model: acknowledge after ack_delay, stay busy hold_for[bit] cycles.
    int ack_delay = 5;
    bit ack_en = 1'b1;
    int hold_for[8];
    int m_phase = 0;
    int m_bit = 0;
    int m_cnt = 0;

    function automatic int low_index(logic [7:0] c);
        for (int i = 0; i < 8; i++) if (!c[i]) return i;
        return 0;
    endfunction

    always @(negedge clk) begin
        case (m_phase)
            0: if (command != 8'hFF && ack_en) begin
                m_bit   = low_index(command);
                m_cnt   = ack_delay;
                m_phase = 1;
            end
            1: if (command == 8'hFF) m_phase = 0;
               else begin
                   m_cnt--;
                   if (m_cnt == 0) begin
                       mod_fb[m_bit] = 1'b0;
                       m_cnt   = hold_for[m_bit];
                       m_phase = 2;
                   end
               end
            2: if (command == 8'hFF) begin
                   mod_fb[m_bit] = 1'b1;
                   m_phase = 0;
               end else begin
                   m_cnt--;
                   if (m_cnt == 0) begin
                       mod_fb[m_bit] = 1'b1;
                       m_phase = 3;
                   end
               end
            default: if (command == 8'hFF) m_phase = 0;
        endcase
    end

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(logic [6:0] mask);
        keys = 7'h7F & ~mask;
        cycles(KEEP);
        keys = 7'h7F;
        cycles(KEEP);
    endtask

    task automatic drain(string name, int budget);
        int n = 0;
        while (expq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL %s: got %0d pending output changes after %0d cycles want 0", name, expq.size(), budget);
            expq.delete();
        end
        cycles(4);
    endtask

    task automatic wait_cmd(logic [7:0] want, int budget);
        int n = 0;
        while (command !== want && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (command !== want) begin
            total++;
            bad++;
            $display("FAIL wait_cmd: got command %h want %h within %0d cycles", command, want, budget);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        keys = 7'h7F;
        rst  = 1'b1;
        for (int i = 0; i < 8; i++) hold_for[i] = 20;
        cycles(3);
        rst = 1'b0;
        check("reset_led", led, 8'h01);
        check("reset_cmd", command, 8'hFF);
        check("reset_busy", busy, 0);
        check("reset_fault", fault, 0);
        last   = {led, command, busy, fault};
        mon_en = 1'b1;

        // Short glitch on next must not register.
        keys = 7'h7F & ~K_NEXT;
        cycles(3);
        keys = 7'h7F;
        cycles(40);
        check("glitch_led", led, 8'h01);

        // prev from 0 wraps to 7; measure key-to-display latency.
        expect_phase("idle", 7);
        keys = 7'h7F & ~K_PREV;
        n = 0;
        while (led == 8'h01 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("key_latency", n, D + 4);
        cycles(KEEP - n);
        keys = 7'h7F;
        cycles(KEEP);
        drain("prev_wrap", 50);
        expect_phase("idle", 0);
        press(K_NEXT);
        expect_phase("idle", 1);
        press(K_NEXT);
        drain("next_twice", 50);
        check("nav_led", led, 8'h02);
        msel = 1;

`ifdef AUTO_CYCLE_EN
        expect_phase("idle", 0); press(K_PREV);
        expect_phase("idle", 7); press(K_PREV);
        expect_phase("idle", 6); press(K_PREV);
        drain("to_sel6", 50);
        hold_for[6] = 20;
        hold_for[7] = 20;
        hold_for[0] = 100000;
        expect_phase("launch", 6); expect_phase("release", 6);
        expect_phase("idle", 7);   expect_phase("launch", 7); expect_phase("release", 7);
        expect_phase("idle", 0);   expect_phase("launch", 0);
        press(K_START);
        drain("auto_chain", 600);
        expect_phase("release", 0);
        expect_phase("idle", 0);
        press(K_STOP);
        drain("auto_stop", 100);
        cycles(100);
        check("auto_stopped_cmd", command, 8'hFF);
        check("auto_stopped_led", led, 8'h01);
        msel = 0;
`else
        // Full launch/run/done handshake on module 2.
        expect_phase("idle", 2);
        press(K_NEXT);
        hold_for[2] = 20;
        ack_delay   = 5;
        expect_phase("launch", 2);
        expect_phase("release", 2);
        expect_phase("idle", 2);
        press(K_START);
        drain("run_sel2", 300);
        check("done_cmd", command, 8'hFF);
        check("done_busy", busy, 0);

        // Module 4 never acknowledges.
        expect_phase("idle", 3); press(K_NEXT);
        expect_phase("idle", 4); press(K_NEXT);
        drain("to_sel4", 50);
        ack_en = 1'b0;
        expect_phase("launch", 4);
        expect_phase("fault", 0);
        keys = 7'h7F & ~K_START;
        wait_cmd(8'hEF, 100);
        n = 0;
        while (!fault && n < 400) begin
            @(negedge clk);
            n++;
            if (n == KEEP) keys = 7'h7F;
        end
        keys = 7'h7F;
        check("ack_timeout_cycles", n, TO);
        cycles(KEEP);
        drain("timeout", 50);
        check("fault_led", led, 8'hFF);
        check("fault_cmd", command, 8'hFF);
        ack_en = 1'b1;
        expect_phase("idle", 4);
        press(K_STOP);
        drain("fault_exit", 50);
        check("fault_exit_led", led, 8'h10);

        // Conflict while module 1 runs.
        expect_phase("idle", 3); press(K_PREV);
        expect_phase("idle", 2); press(K_PREV);
        expect_phase("idle", 1); press(K_PREV);
        hold_for[1] = 100000;
        expect_phase("launch", 1);
        press(K_START);
        drain("run_sel1", 50);
        expect_phase("fault", 0);
        ext_fb = 8'hDF;
        n = 0;
        while (!fault && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("foreign_fault_latency", n, 1);
        ext_fb = 8'hFF;
        drain("foreign", 20);
        expect_phase("idle", 1);
        press(K_STOP);
        drain("foreign_exit", 50);

        // stop and next together while running.
        expect_phase("launch", 1);
        press(K_START);
        drain("run_sel1b", 50);
        expect_phase("release", 1);
        expect_phase("idle", 1);
        press(K_STOP | K_NEXT);
        drain("stop_next", 50);
        check("stop_next_led", led, 8'h02);

        for (int it = 0; it < 12; it++) begin
            int op;
            op = $urandom_range(0, 4);
            case (op)
                0: begin
                    msel = (msel + 1) % 8;
                    expect_phase("idle", msel);
                    press(K_NEXT);
                end
                1: begin
                    msel = (msel + 7) % 8;
                    expect_phase("idle", msel);
                    press(K_PREV);
                end
                2: begin
                    hold_for[msel] = $urandom_range(1, 30);
                    ack_delay      = $urandom_range(1, 10);
                    expect_phase("launch", msel);
                    expect_phase("release", msel);
                    expect_phase("idle", msel);
                    press(K_START);
                end
                3: begin
                    hold_for[msel] = 100000;
                    ack_delay      = $urandom_range(1, 10);
                    expect_phase("launch", msel);
                    press(K_START);
                    expect_phase("release", msel);
                    expect_phase("idle", msel);
                    press(K_STOP);
                end
                default: begin
                    ext_fb = ~bit_of($urandom_range(0, 7));
                    press(K_START);
                    check("busy_start_ignored", command, 8'hFF);
                    ext_fb = 8'hFF;
                end
            endcase
            drain("random_op", 400);
        end
`endif

        // Reset while a module is running drops the launch line on that edge.
        hold_for[msel] = 100000;
        ack_delay      = 3;
        expect_phase("launch", msel);
        press(K_START);
        drain("pre_reset_run", 50);
        mon_en = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        check("reset_midrun_cmd", command, 8'hFF);
        check("reset_midrun_led", led, 8'h01);
        check("reset_midrun_busy", busy, 0);
        rst = 1'b0;
        cycles(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
